// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Build option: IMEM_LOADER_CHECKSUM_EN adds the CHK state.
package imem_loader_pkg;

    localparam int unsigned HDR_LEN        = 2;
    localparam int unsigned BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK    = 3'd4,
`endif
        RUN    = 3'd5,
        ERR    = 3'd6
    } state_t;

endpackage

// File: rtl/byte_packer.sv
// Packs a big-endian byte stream into 32-bit words; o_word_valid pulses
// for one cycle after the fourth byte, and o_word holds until the next word.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clear,
    input  logic        i_valid,
    input  logic [7:0]  i_byte,
    output logic        o_last,
    output logic        o_word_valid,
    output logic [31:0] o_word
);

    logic [1:0]  r_cnt;
    logic [23:0] r_shift;
    logic [31:0] r_word;
    logic        r_word_valid;

    assign o_last       = i_valid && (r_cnt == 2'(BYTES_PER_WORD - 1));
    assign o_word       = r_word;
    assign o_word_valid = r_word_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_shift      <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= 1'b0;
            if (i_clear) begin
                r_cnt <= '0;
            end else if (i_valid) begin
                if (o_last) begin
                    r_word       <= {r_shift, i_byte};
                    r_word_valid <= 1'b1;
                    r_cnt        <= '0;
                end else begin
                    r_shift <= {r_shift[15:0], i_byte};
                    r_cnt   <= r_cnt + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed program over a byte stream and
// writes it into instruction memory. Build option: IMEM_LOADER_CHECKSUM_EN.
module imem_boot_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH  = 100,
    parameter int unsigned ADDR_W = 7
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_run,
    output logic              busy,
    output logic              error
);

    state_t            r_state;
    logic [7:0]        r_len_hi;
    logic [15:0]       r_len;
    logic [ADDR_W-1:0] r_wcnt;
    logic [ADDR_W-1:0] r_waddr;
    logic              r_cpu_run;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        r_xor;
`endif

    logic        w_active;
    logic        w_xfer;
    logic        w_clear;
    logic        w_pack_valid;
    logic        w_word_done;
    logic        w_last_word;
    logic [15:0] w_len;

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign w_active = (r_state == LEN_HI) || (r_state == LEN_LO) ||
                      (r_state == DATA)   || (r_state == CHK);
`else
    assign w_active = (r_state == LEN_HI) || (r_state == LEN_LO) ||
                      (r_state == DATA);
`endif

    assign w_xfer       = rx_valid && w_active;
    assign w_clear      = start && ((r_state == IDLE) || (r_state == RUN) || (r_state == ERR));
    assign w_pack_valid = w_xfer && (r_state == DATA);
    assign w_len        = {r_len_hi, rx_data};
    assign w_last_word  = (16'(r_wcnt) == (r_len - 16'd1));

    assign rx_ready  = w_active;
    assign busy      = w_active;
    assign error     = (r_state == ERR);
    assign cpu_run   = r_cpu_run;
    assign mem_waddr = r_waddr;

    byte_packer u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (w_clear),
        .i_valid      (w_pack_valid),
        .i_byte       (rx_data),
        .o_last       (w_word_done),
        .o_word_valid (mem_we),
        .o_word       (mem_wdata)
    );

    // The address is latched with the fourth byte so it lines up with the
    // packer's registered write strobe one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_len_hi  <= '0;
            r_len     <= '0;
            r_wcnt    <= '0;
            r_waddr   <= '0;
            r_cpu_run <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_xor     <= '0;
`endif
        end else begin
            case (r_state)
                IDLE, RUN, ERR: begin
                    if (r_state == RUN)
                        r_cpu_run <= 1'b1;
                    if (start) begin
                        r_state   <= LEN_HI;
                        r_cpu_run <= 1'b0;
                        r_wcnt    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_xor     <= '0;
`endif
                    end
                end
                LEN_HI: begin
                    if (w_xfer) begin
                        r_len_hi <= rx_data;
                        r_state  <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (w_xfer) begin
                        r_len <= w_len;
                        if ((w_len == 16'd0) || (w_len > 16'(DEPTH)))
                            r_state <= ERR;
                        else
                            r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_xor <= r_xor ^ rx_data;
`endif
                        if (w_word_done) begin
                            r_waddr <= r_wcnt;
                            if (w_last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                r_state <= CHK;
`else
                                r_state <= RUN;
`endif
                            end else begin
                                r_wcnt <= r_wcnt + ADDR_W'(1);
                            end
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHK: begin
                    if (w_xfer)
                        r_state <= (rx_data == r_xor) ? RUN : ERR;
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed self-checking bench for imem_boot_loader (default and
// IMEM_LOADER_CHECKSUM_EN builds).
module tb_imem_boot_loader;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b1;
    logic        start    = 1'b0;
    logic [7:0]  rx_data  = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        mem_we;
    logic [6:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        cpu_run;
    logic        busy;
    logic        error;

    imem_boot_loader #(.DEPTH(100), .ADDR_W(7)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .cpu_run   (cpu_run),
        .busy      (busy),
        .error     (error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int we_wide  = 0;
    int unstable = 0;

    logic [6:0]  wq_addr[$];
    logic [31:0] wq_data[$];
    int          wq_cyc[$];
    int          run_q[$];
    logic [7:0]  txq[$];

    logic        prev_we   = 1'b0;
    logic        prev_run  = 1'b0;
    logic [6:0]  prev_addr = '0;
    logic [31:0] prev_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Write/run monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we) begin
                wq_addr.push_back(mem_waddr);
                wq_data.push_back(mem_wdata);
                wq_cyc.push_back(cyc);
                if (prev_we) we_wide <= we_wide + 1;
            end else if (!prev_we && ((mem_waddr !== prev_addr) || (mem_wdata !== prev_data))) begin
                unstable <= unstable + 1;
            end
            if (cpu_run && !prev_run) run_q.push_back(cyc);
        end
        prev_we   <= mem_we;
        prev_run  <= cpu_run;
        prev_addr <= mem_waddr;
        prev_data <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        wq_addr.delete();
        wq_data.delete();
        wq_cyc.delete();
        run_q.delete();
    endtask

    task automatic do_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic push_chk(input logic [7:0] x);
`ifdef IMEM_LOADER_CHECKSUM_EN
        txq.push_back(x);
`else
        if (x == 8'hxx) txq.push_back(x);
`endif
    endtask

    task automatic send_all(input int gap);
        logic [7:0] b;
        int t;
        while (txq.size() > 0) begin
            b = txq.pop_front();
            repeat (gap) @(negedge clk);
            @(negedge clk);
            rx_data  = b;
            rx_valid = 1'b1;
            t = 0;
            while (!rx_ready && t < 20) begin
                @(negedge clk);
                t++;
            end
            if (!rx_ready) begin
                chk("rx_ready_wait", {31'b0, rx_ready}, 32'd1);
                rx_valid = 1'b0;
                txq.delete();
                return;
            end
            @(posedge clk);
            #1 rx_valid = 1'b0;
        end
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!cpu_run && !error && t < 40) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
    endtask

    task automatic chk_run_timing(input string tag);
        if ((run_q.size() == 0) || (wq_cyc.size() == 0)) begin
            chk({tag, "_run_seen"}, 32'(run_q.size()), 32'd1);
        end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk({tag, "_run_after_we"}, {31'b0, run_q[0] > wq_cyc[wq_cyc.size()-1]}, 32'd1);
`else
            chk({tag, "_run_cyc"}, 32'(run_q[0]), 32'(wq_cyc[wq_cyc.size()-1] + 1));
`endif
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rx_ready"},  {31'b0, rx_ready}, 32'd0);
        chk({tag, "_mem_we"},    {31'b0, mem_we},   32'd0);
        chk({tag, "_mem_waddr"}, 32'(mem_waddr),    32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata,         32'd0);
        chk({tag, "_cpu_run"},   {31'b0, cpu_run},  32'd0);
        chk({tag, "_busy"},      {31'b0, busy},     32'd0);
        chk({tag, "_error"},     {31'b0, error},    32'd0);
    endtask

    initial begin
        // Power-on reset
        #3 rst_n = 1'b0;
        #1 chk_reset_outputs("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("por_no_write", 32'(wq_addr.size()), 32'd0);

        // Two-word load
        clear_mon();
        do_start();
        chk("t1_busy",     {31'b0, busy},     32'd1);
        chk("t1_rx_ready", {31'b0, rx_ready}, 32'd1);
        txq = {8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h24, 8'h08, 8'h00, 8'h05};
        push_chk(8'h0B);
        send_all(0);
        wait_done();
        chk("t1_n_writes", 32'(wq_addr.size()), 32'd2);
        chk("t1_addr0",    32'(wq_addr[0]),     32'd0);
        chk("t1_data0",    wq_data[0],          32'hDEADBEEF);
        chk("t1_addr1",    32'(wq_addr[1]),     32'd1);
        chk("t1_data1",    wq_data[1],          32'h24080005);
        chk("t1_cpu_run",  {31'b0, cpu_run},    32'd1);
        chk("t1_busy_off", {31'b0, busy},       32'd0);
        chk("t1_ready_off",{31'b0, rx_ready},   32'd0);
        chk("t1_error",    {31'b0, error},      32'd0);
        chk_run_timing("t1");

        // Zero length, then length 101 (one past DEPTH)
        clear_mon();
        do_start();
        chk("t2_cpu_run_cleared", {31'b0, cpu_run}, 32'd0);
        txq = {8'h00, 8'h00};
        send_all(0);
        @(negedge clk);
        chk("t2_len0_error",    {31'b0, error},    32'd1);
        chk("t2_len0_rx_ready", {31'b0, rx_ready}, 32'd0);
        chk("t2_len0_busy",     {31'b0, busy},     32'd0);
        chk("t2_len0_cpu_run",  {31'b0, cpu_run},  32'd0);
        do_start();
        chk("t2_err_cleared",   {31'b0, error},    32'd0);
        chk("t2_restart_busy",  {31'b0, busy},     32'd1);
        txq = {8'h00, 8'h65};
        send_all(0);
        repeat (3) @(negedge clk);
        chk("t2_len101_error",    {31'b0, error},    32'd1);
        chk("t2_len101_rx_ready", {31'b0, rx_ready}, 32'd0);
        chk("t2_len101_cpu_run",  {31'b0, cpu_run},  32'd0);
        chk("t2_no_writes",       32'(wq_addr.size()), 32'd0);

        // Three-word load with 5-cycle gaps between bytes
        clear_mon();
        do_start();
        txq = {8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h13, 8'hCA, 8'hFE, 8'hF0, 8'h0D,
               8'h12, 8'h34, 8'h56, 8'h78};
        push_chk(8'hD2);
        send_all(5);
        wait_done();
        chk("t3_n_writes", 32'(wq_addr.size()), 32'd3);
        chk("t3_addr0",    32'(wq_addr[0]),     32'd0);
        chk("t3_data0",    wq_data[0],          32'h00000013);
        chk("t3_addr1",    32'(wq_addr[1]),     32'd1);
        chk("t3_data1",    wq_data[1],          32'hCAFEF00D);
        chk("t3_addr2",    32'(wq_addr[2]),     32'd2);
        chk("t3_data2",    wq_data[2],          32'h12345678);
        chk("t3_cpu_run",  {31'b0, cpu_run},    32'd1);
        chk_run_timing("t3");

        // Reset after the second data byte, then a fresh one-word load
        clear_mon();
        do_start();
        txq = {8'h00, 8'h02, 8'h11, 8'h22};
        send_all(0);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("t4_rst");
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t4_no_write", 32'(wq_addr.size()), 32'd0);
        do_start();
        txq = {8'h00, 8'h01, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
        push_chk(8'h04);
        send_all(0);
        wait_done();
        chk("t4_n_writes", 32'(wq_addr.size()), 32'd1);
        chk("t4_addr0",    32'(wq_addr[0]),     32'd0);
        chk("t4_data0",    wq_data[0],          32'hA1B2C3D4);
        chk("t4_cpu_run",  {31'b0, cpu_run},    32'd1);

        // Start pulse in the middle of DATA is ignored
        clear_mon();
        do_start();
        txq = {8'h00, 8'h02, 8'h01, 8'h02};
        send_all(0);
        do_start();
        chk("t5_busy_kept",  {31'b0, busy},     32'd1);
        chk("t5_ready_kept", {31'b0, rx_ready}, 32'd1);
        txq = {8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        push_chk(8'h08);
        send_all(0);
        wait_done();
        chk("t5_n_writes", 32'(wq_addr.size()), 32'd2);
        chk("t5_data0",    wq_data[0],          32'h01020304);
        chk("t5_addr1",    32'(wq_addr[1]),     32'd1);
        chk("t5_data1",    wq_data[1],          32'h05060708);
        chk("t5_cpu_run",  {31'b0, cpu_run},    32'd1);
        chk_run_timing("t5");

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum match and mismatch
        clear_mon();
        do_start();
        txq = {8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        send_all(0);
        wait_done();
        chk("t6_good_cpu_run", {31'b0, cpu_run}, 32'd1);
        chk("t6_good_error",   {31'b0, error},   32'd0);
        chk("t6_good_data",    wq_data[0],       32'h11223344);
        clear_mon();
        do_start();
        txq = {8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
        send_all(0);
        wait_done();
        chk("t6_bad_error",    {31'b0, error},    32'd1);
        chk("t6_bad_cpu_run",  {31'b0, cpu_run},  32'd0);
        chk("t6_bad_rx_ready", {31'b0, rx_ready}, 32'd0);
`endif

        chk("we_single_cycle", 32'(we_wide),  32'd0);
        chk("wr_bus_stable",   32'(unstable), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
